// File: rtl/instr_encoder_stream.sv
// instr_encoder_stream
// Packs abstract Thumb-subset instruction descriptors into 16-bit words and
// streams them into instruction memory at an auto-incrementing address.
// Descriptors that cannot be encoded are consumed and flagged on err_o
// instead of being written. Once the last address has been written the
// block parks in FULL until clear_i or reset.
module instr_encoder_stream #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [3:0]        req_rd_i,
  input  logic [3:0]        req_rn_i,
  input  logic [3:0]        req_rm_i,
  input  logic [10:0]       req_imm_i,
  input  logic [3:0]        req_cond_i,
  output logic              wr_en_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o
);

  // Descriptor opcodes
  localparam logic [4:0] OP_MOVS  = 5'd0;
  localparam logic [4:0] OP_MOV   = 5'd1;
  localparam logic [4:0] OP_ADDI  = 5'd2;
  localparam logic [4:0] OP_ADDS  = 5'd3;
  localparam logic [4:0] OP_ADDSP = 5'd4;
  localparam logic [4:0] OP_SUBS  = 5'd5;
  localparam logic [4:0] OP_SUBI  = 5'd6;
  localparam logic [4:0] OP_SUBSP = 5'd7;
  localparam logic [4:0] OP_CMP   = 5'd8;
  localparam logic [4:0] OP_ANDS  = 5'd9;
  localparam logic [4:0] OP_EORS  = 5'd10;
  localparam logic [4:0] OP_ORRS  = 5'd11;
  localparam logic [4:0] OP_MVNS  = 5'd12;
  localparam logic [4:0] OP_LSLS  = 5'd13;
  localparam logic [4:0] OP_LSRS  = 5'd14;
  localparam logic [4:0] OP_ASRS  = 5'd15;
  localparam logic [4:0] OP_RORS  = 5'd16;
  localparam logic [4:0] OP_B     = 5'd17;
  localparam logic [4:0] OP_CB    = 5'd18;
  localparam logic [4:0] OP_BL    = 5'd19;
  localparam logic [4:0] OP_BX    = 5'd20;
  localparam logic [4:0] OP_LDUR  = 5'd21;
  localparam logic [4:0] OP_STUR  = 5'd22;
  localparam logic [4:0] OP_NOOP  = 5'd23;

  // Reject codes
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OP   = 2'd1;
  localparam logic [1:0] ERR_REG  = 2'd2;
  localparam logic [1:0] ERR_IMM  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // True when the zero-extended immediate needs more than 'bits' bits
  function automatic logic imm_over(input logic [10:0] imm, input int unsigned bits);
    logic [10:0] hi;
    hi = imm >> bits;
    return (hi != 11'd0);
  endfunction

  // Two-operand 3-bit register form shared by CMP and the ALU group
  function automatic logic [15:0] pack_rr(input logic [9:0] prefix,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    return {prefix, ra[2:0], rb[2:0]};
  endfunction

  // Three-field 3-bit form shared by ADDI/ADDS/SUBS/SUBI
  function automatic logic [15:0] pack_rrr(input logic [6:0] prefix,
                                           input logic [2:0] f2,
                                           input logic [3:0] rn,
                                           input logic [3:0] rd);
    return {prefix, f2, rn[2:0], rd[2:0]};
  endfunction

  state_t              state_r;
  logic                wr_en_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [15:0]         wr_data_r;
  logic                err_r;
  logic [1:0]          err_code_r;
  logic [ADDR_W:0]     count_r;

  logic [15:0]         enc_word_s;
  logic                op_bad_s;
  logic                reg_bad_s;
  logic                imm_bad_s;
  logic [1:0]          enc_code_s;
  logic                wr_hs_s;
  logic                last_hs_s;
  logic                req_ready_s;
  logic                accept_s;

  // Encode the current descriptor and flag which checks it fails
  always_comb begin
    enc_word_s = 16'h0000;
    op_bad_s   = 1'b0;
    reg_bad_s  = 1'b0;
    imm_bad_s  = 1'b0;
    case (req_op_i)
      OP_MOVS: begin
        enc_word_s = {5'b00100, req_rd_i[2:0], req_imm_i[7:0]};
        reg_bad_s  = req_rd_i[3];
        imm_bad_s  = imm_over(req_imm_i, 8);
      end
      OP_MOV: begin
        enc_word_s = {9'b010001100, req_rm_i, req_rd_i[2:0]};
        reg_bad_s  = req_rd_i[3];
      end
      OP_ADDI: begin
        enc_word_s = pack_rrr(7'b0001110, req_imm_i[2:0], req_rn_i, req_rd_i);
        reg_bad_s  = req_rn_i[3] | req_rd_i[3];
        imm_bad_s  = imm_over(req_imm_i, 3);
      end
      OP_ADDS: begin
        enc_word_s = pack_rrr(7'b0001100, req_rm_i[2:0], req_rn_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rn_i[3] | req_rd_i[3];
      end
      OP_ADDSP: begin
        enc_word_s = {9'b101100000, req_imm_i[6:0]};
        imm_bad_s  = imm_over(req_imm_i, 7);
      end
      OP_SUBS: begin
        enc_word_s = pack_rrr(7'b0001101, req_rm_i[2:0], req_rn_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rn_i[3] | req_rd_i[3];
      end
      OP_SUBI: begin
        enc_word_s = pack_rrr(7'b0001111, req_imm_i[2:0], req_rn_i, req_rd_i);
        reg_bad_s  = req_rn_i[3] | req_rd_i[3];
        imm_bad_s  = imm_over(req_imm_i, 3);
      end
      OP_SUBSP: begin
        enc_word_s = {9'b101100001, req_imm_i[6:0]};
        imm_bad_s  = imm_over(req_imm_i, 7);
      end
      OP_CMP: begin
        enc_word_s = pack_rr(10'b0100001010, req_rm_i, req_rn_i);
        reg_bad_s  = req_rm_i[3] | req_rn_i[3];
      end
      OP_ANDS: begin
        enc_word_s = pack_rr(10'b0100000000, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_EORS: begin
        enc_word_s = pack_rr(10'b0100000001, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_ORRS: begin
        enc_word_s = pack_rr(10'b0100001100, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_MVNS: begin
        enc_word_s = pack_rr(10'b0100001111, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_LSLS: begin
        enc_word_s = pack_rr(10'b0100000010, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_LSRS: begin
        enc_word_s = pack_rr(10'b0100000011, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_ASRS: begin
        enc_word_s = pack_rr(10'b0100000100, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_RORS: begin
        enc_word_s = pack_rr(10'b0100000111, req_rm_i, req_rd_i);
        reg_bad_s  = req_rm_i[3] | req_rd_i[3];
      end
      OP_B: begin
        enc_word_s = {5'b11100, req_imm_i};
      end
      OP_CB: begin
        enc_word_s = {4'b1101, req_cond_i, req_imm_i[7:0]};
        imm_bad_s  = imm_over(req_imm_i, 8) | (req_cond_i >= 4'd14);
      end
      OP_BL: begin
        enc_word_s = {10'b0100010100, req_imm_i[5:0]};
        imm_bad_s  = imm_over(req_imm_i, 6);
      end
      OP_BX: begin
        enc_word_s = {9'b010001110, req_rm_i, 3'b000};
      end
      OP_LDUR: begin
        enc_word_s = {5'b01101, req_imm_i[4:0], req_rn_i[2:0], req_rd_i[2:0]};
        reg_bad_s  = req_rn_i[3] | req_rd_i[3];
        imm_bad_s  = imm_over(req_imm_i, 5);
      end
      OP_STUR: begin
        enc_word_s = {5'b01100, req_imm_i[4:0], req_rn_i[2:0], req_rd_i[2:0]};
        reg_bad_s  = req_rn_i[3] | req_rd_i[3];
        imm_bad_s  = imm_over(req_imm_i, 5);
      end
      OP_NOOP: begin
        enc_word_s = 16'hBF00;
      end
      default: begin
        op_bad_s   = 1'b1;
      end
    endcase
  end

  // Resolve reject priority: opcode, then registers, then immediate/cond
  always_comb begin
    enc_code_s = ERR_NONE;
    if (op_bad_s) begin
      enc_code_s = ERR_OP;
    end else if (reg_bad_s) begin
      enc_code_s = ERR_REG;
    end else if (imm_bad_s) begin
      enc_code_s = ERR_IMM;
    end else begin
      enc_code_s = ERR_NONE;
    end
  end

  // Handshake decode; the final-address write blocks a same-cycle accept
  always_comb begin
    wr_hs_s     = wr_en_r & wr_ready_i;
    last_hs_s   = wr_hs_s & (wr_addr_r == LAST_ADDR);
    req_ready_s = (state_r == ST_RUN) & ~clear_i &
                  (~wr_en_r | (wr_ready_i & (wr_addr_r != LAST_ADDR)));
    accept_s    = req_valid_i & req_ready_s;
  end

  // Control FSM and registered output stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_RUN;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= BASE_A;
      wr_data_r  <= 16'h0000;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      count_r    <= '0;
    end else if (clear_i) begin
      // Pending word is dropped; the last error code is kept for inspection
      state_r    <= ST_RUN;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= BASE_A;
      wr_data_r  <= 16'h0000;
      err_r      <= 1'b0;
      count_r    <= '0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (wr_hs_s) begin
            wr_en_r <= 1'b0;
            count_r <= count_r + (ADDR_W+1)'(1);
            if (last_hs_s) begin
              state_r <= ST_FULL;
            end else begin
              wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end
          end
          if (accept_s) begin
            if (enc_code_s != ERR_NONE) begin
              err_r      <= 1'b1;
              err_code_r <= enc_code_s;
            end else begin
              wr_en_r   <= 1'b1;
              wr_data_r <= enc_word_s;
            end
          end
        end
        ST_FULL: begin
          wr_en_r <= 1'b0;
        end
        default: begin
          state_r <= ST_RUN;
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_s;
  assign wr_en_o     = wr_en_r;
  assign wr_addr_o   = wr_addr_r;
  assign wr_data_o   = wr_data_r;
  assign err_o       = err_r;
  assign err_code_o  = err_code_r;
  assign full_o      = (state_r == ST_FULL);
  assign count_o     = count_r;

endmodule

// File: tb/tb_instr_encoder_stream.sv
// Directed bench for instr_encoder_stream: one default-size instance for the
// encoding/handshake/reject behaviour and one ADDR_W=2 instance for FULL.
module tb_instr_encoder_stream;

  logic        clk;
  logic        rst_n;
  logic [4:0]  op;
  logic [3:0]  rd, rn, rm, cond;
  logic [10:0] imm;

  logic        clear1, valid1, ready1, wr_ready1, wr_en1, err1, full1;
  logic [7:0]  addr1;
  logic [15:0] data1;
  logic [1:0]  code1;
  logic [8:0]  count1;

  logic        clear2, valid2, ready2, wr_ready2, wr_en2, err2, full2;
  logic [1:0]  addr2;
  logic [15:0] data2;
  logic [1:0]  code2;
  logic [2:0]  count2;

  int n_chk;
  int n_err;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  rd, rn, rm;
    logic [10:0] imm;
    logic [3:0]  cond;
    logic [15:0] exp;
  } vec_t;

  vec_t good_v [7];
  vec_t bad_v  [6];

  instr_encoder_stream dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear1),
    .req_valid_i(valid1), .req_ready_o(ready1),
    .req_op_i(op), .req_rd_i(rd), .req_rn_i(rn), .req_rm_i(rm),
    .req_imm_i(imm), .req_cond_i(cond),
    .wr_en_o(wr_en1), .wr_ready_i(wr_ready1), .wr_addr_o(addr1), .wr_data_o(data1),
    .err_o(err1), .err_code_o(code1), .full_o(full1), .count_o(count1)
  );

  instr_encoder_stream #(.ADDR_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear2),
    .req_valid_i(valid2), .req_ready_o(ready2),
    .req_op_i(op), .req_rd_i(rd), .req_rn_i(rn), .req_rm_i(rm),
    .req_imm_i(imm), .req_cond_i(cond),
    .wr_en_o(wr_en2), .wr_ready_i(wr_ready2), .wr_addr_o(addr2), .wr_data_o(data2),
    .err_o(err2), .err_code_o(code2), .full_o(full2), .count_o(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input vec_t v);
    op = v.op; rd = v.rd; rn = v.rn; rm = v.rm; imm = v.imm; cond = v.cond;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    // op, rd, rn, rm, imm, cond, expected word
    good_v[0] = '{5'd1,  4'd2, 4'd0, 4'd10, 11'd0,   4'd0,  16'h4652}; // MOV
    good_v[1] = '{5'd8,  4'd0, 4'd5, 4'd3,  11'd0,   4'd0,  16'h429D}; // CMP
    good_v[2] = '{5'd20, 4'd0, 4'd0, 4'd14, 11'd0,   4'd0,  16'h4770}; // BX
    good_v[3] = '{5'd7,  4'd0, 4'd0, 4'd0,  11'd127, 4'd0,  16'hB0FF}; // SUBSP max
    good_v[4] = '{5'd18, 4'd0, 4'd0, 4'd0,  11'h12,  4'd13, 16'hDD12}; // CB cond 13
    good_v[5] = '{5'd19, 4'd0, 4'd0, 4'd0,  11'd63,  4'd0,  16'h453F}; // BL max
    good_v[6] = '{5'd16, 4'd6, 4'd0, 4'd7,  11'd0,   4'd0,  16'h41FE}; // RORS
    // rejects; exp holds the expected error code
    bad_v[0]  = '{5'd3,  4'd1, 4'd2, 4'd9,  11'd0,   4'd0,  16'd2};    // ADDS rm=9
    bad_v[1]  = '{5'd21, 4'd0, 4'd1, 4'd0,  11'd40,  4'd0,  16'd3};    // LDUR imm=40
    bad_v[2]  = '{5'd25, 4'd0, 4'd0, 4'd0,  11'd0,   4'd0,  16'd1};    // op 25
    bad_v[3]  = '{5'd18, 4'd0, 4'd0, 4'd0,  11'd1,   4'd15, 16'd3};    // CB cond=15
    bad_v[4]  = '{5'd2,  4'd1, 4'd2, 4'd0,  11'd8,   4'd0,  16'd3};    // ADDI imm=8
    bad_v[5]  = '{5'd0,  4'd8, 4'd0, 4'd0,  11'd300, 4'd0,  16'd2};    // MOVS reg beats imm

    rst_n = 1'b0; clear1 = 1'b0; valid1 = 1'b0; wr_ready1 = 1'b1;
    clear2 = 1'b0; valid2 = 1'b0; wr_ready2 = 1'b1;
    op = 5'd0; rd = 4'd0; rn = 4'd0; rm = 4'd0; imm = 11'd0; cond = 4'd0;

    // Reset values
    #3;
    check("rst_wr_en", 32'(wr_en1), 32'd0);
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_code", 32'(code1), 32'd0);
    check("rst_full", 32'(full1), 32'd0);
    check("rst_count", 32'(count1), 32'd0);
    #9 rst_n = 1'b1;
    tick;
    check("rst_ready", 32'(ready1), 32'd1);

    // ADDI rd=1 rn=2 imm=5
    op = 5'd2; rd = 4'd1; rn = 4'd2; imm = 11'd5; valid1 = 1'b1;
    tick;
    valid1 = 1'b0;
    check("addi_wr_en", 32'(wr_en1), 32'd1);
    check("addi_addr", 32'(addr1), 32'd0);
    check("addi_data", 32'(data1), 32'h1D51);
    tick;
    check("addi_count", 32'(count1), 32'd1);
    check("addi_addr_after", 32'(addr1), 32'd1);
    check("addi_wr_en_after", 32'(wr_en1), 32'd0);

    // clear blocks ready and restarts the address
    clear1 = 1'b1;
    #1 check("clear_ready", 32'(ready1), 32'd0);
    tick;
    clear1 = 1'b0;
    check("clear_addr", 32'(addr1), 32'd0);
    check("clear_count", 32'(count1), 32'd0);

    // Back-to-back stream MOVS, B, NOOP
    op = 5'd0; rd = 4'd3; imm = 11'hA5; valid1 = 1'b1;
    tick;
    check("movs_data", 32'(data1), 32'h23A5);
    check("movs_addr", 32'(addr1), 32'd0);
    op = 5'd17; imm = 11'h7FF;
    check("b2b_ready", 32'(ready1), 32'd1);
    tick;
    check("b_data", 32'(data1), 32'hE7FF);
    check("b_addr", 32'(addr1), 32'd1);
    op = 5'd23;
    tick;
    check("noop_data", 32'(data1), 32'hBF00);
    check("noop_addr", 32'(addr1), 32'd2);
    check("noop_wr_en", 32'(wr_en1), 32'd1);

    // Further encodings streamed at addresses 3..9
    for (int i = 0; i < 7; i++) begin
      set_req(good_v[i]);
      tick;
      check($sformatf("enc%0d_data", i), 32'(data1), 32'(good_v[i].exp));
      check($sformatf("enc%0d_addr", i), 32'(addr1), 32'(3 + i));
    end
    valid1 = 1'b0;
    tick;
    check("stream_count", 32'(count1), 32'd10);
    check("stream_addr", 32'(addr1), 32'd10);

    // Backpressure on STUR rd=0 rn=1 imm=4
    op = 5'd22; rd = 4'd0; rn = 4'd1; imm = 11'd4; valid1 = 1'b1; wr_ready1 = 1'b0;
    tick;
    valid1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_data", i), 32'(data1), 32'h6108);
      check($sformatf("bp%0d_wr_en", i), 32'(wr_en1), 32'd1);
      check($sformatf("bp%0d_addr", i), 32'(addr1), 32'd10);
      check($sformatf("bp%0d_ready", i), 32'(ready1), 32'd0);
      tick;
    end
    wr_ready1 = 1'b1;
    #1 check("bp_release_ready", 32'(ready1), 32'd1);
    tick;
    check("bp_addr_after", 32'(addr1), 32'd11);
    check("bp_count_after", 32'(count1), 32'd11);

    // Rejects: pulse, code, nothing written
    for (int i = 0; i < 6; i++) begin
      set_req(bad_v[i]);
      valid1 = 1'b1;
      tick;
      valid1 = 1'b0;
      check($sformatf("rej%0d_err", i), 32'(err1), 32'd1);
      check($sformatf("rej%0d_code", i), 32'(code1), 32'(bad_v[i].exp));
      check($sformatf("rej%0d_wr_en", i), 32'(wr_en1), 32'd0);
      tick;
      check($sformatf("rej%0d_err_pulse", i), 32'(err1), 32'd0);
      check($sformatf("rej%0d_code_hold", i), 32'(code1), 32'(bad_v[i].exp));
    end
    check("rej_addr", 32'(addr1), 32'd11);
    check("rej_count", 32'(count1), 32'd11);

    // Reject accepted on the same edge a previous write completes
    op = 5'd23; valid1 = 1'b1;
    tick;
    op = 5'd3; rd = 4'd1; rn = 4'd2; rm = 4'd9;
    tick;
    valid1 = 1'b0;
    check("coinc_err", 32'(err1), 32'd1);
    check("coinc_code", 32'(code1), 32'd2);
    check("coinc_wr_en", 32'(wr_en1), 32'd0);
    check("coinc_count", 32'(count1), 32'd12);
    check("coinc_addr", 32'(addr1), 32'd12);

    // ADDR_W=2 instance fills up
    op = 5'd23; valid2 = 1'b1;
    #1 check("w2_ready_start", 32'(ready2), 32'd1);
    tick; tick; tick; tick;
    check("w2_last_pending_addr", 32'(addr2), 32'd3);
    check("w2_last_ready", 32'(ready2), 32'd0);
    tick;
    check("w2_full", 32'(full2), 32'd1);
    check("w2_full_ready", 32'(ready2), 32'd0);
    check("w2_full_count", 32'(count2), 32'd4);
    check("w2_full_addr", 32'(addr2), 32'd3);
    check("w2_full_wr_en", 32'(wr_en2), 32'd0);
    tick;
    check("w2_hold_count", 32'(count2), 32'd4);
    check("w2_hold_full", 32'(full2), 32'd1);
    valid2 = 1'b0; clear2 = 1'b1;
    tick;
    clear2 = 1'b0;
    #1;
    check("w2_clr_addr", 32'(addr2), 32'd0);
    check("w2_clr_count", 32'(count2), 32'd0);
    check("w2_clr_full", 32'(full2), 32'd0);
    check("w2_clr_ready", 32'(ready2), 32'd1);

    // Async reset while a word is held by backpressure
    op = 5'd23; valid1 = 1'b1; wr_ready1 = 1'b0;
    tick;
    valid1 = 1'b0;
    check("ar_pending", 32'(wr_en1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wr_en", 32'(wr_en1), 32'd0);
    check("ar_addr", 32'(addr1), 32'd0);
    check("ar_data", 32'(data1), 32'd0);
    check("ar_count", 32'(count1), 32'd0);
    check("ar_code", 32'(code1), 32'd0);
    #1 rst_n = 1'b1; wr_ready1 = 1'b1;
    tick;
    check("ar_ready", 32'(ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
